// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ_ADD    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_e;

endpackage

// File: rtl/bcd_converter_if.sv
// Request/result bundle between a requester (master) and bcd_converter (slave).
interface bcd_converter_if
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) ();

    logic                          start;
    logic [WIDTH-1:0]              dado;
    logic                          busy;
    logic                          done;
    logic [DIGITS*BCD_DIGIT_W-1:0] bcd;
    logic                          neg;
    logic                          overflow;
    logic [DIGITS-1:0]             blank;

    modport master (
        output start, dado,
        input  busy, done, bcd, neg, overflow, blank
    );

    modport slave (
        input  start, dado,
        output busy, done, bcd, neg, overflow, blank
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    // Conditional add-3 on one digit.
    always_comb begin
        if (digit_i >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) begin
            digit_o = digit_i + BCD_DIGIT_W'(BCD_ADJ_ADD);
        end else begin
            digit_o = digit_i;
        end
    end

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle).
// Optional leading-zero blanking mask: define BCD_LEADING_ZERO_BLANK_EN.
// The done pulse arrives WIDTH+1 cycles after start is accepted; results
// are loaded on that same edge and held until the next done.
module bcd_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DIGITS    = 10,
    parameter int SIGNED_IN = 1
) (
    input  logic           clock,
    input  logic           reset,
    bcd_converter_if.slave bus
);

    localparam int BCD_W = DIGITS * BCD_DIGIT_W;
    localparam int CNT_W = $clog2(WIDTH + 1);

    bcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [BCD_W-1:0] work_q, work_d;
    logic             ovf_work_q, ovf_work_d;
    logic             neg_work_q, neg_work_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             neg_q, neg_d;
    logic             overflow_q, overflow_d;
    logic [DIGITS-1:0] blank_q, blank_d;

    logic [BCD_W-1:0]  adj_s;
    logic [WIDTH-1:0]  in_mag_s;
    logic              in_neg_s;
    logic [DIGITS-1:0] blank_s;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit_i (work_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .digit_o (adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Split the incoming value into sign and unsigned magnitude.
    always_comb begin
        in_neg_s = (SIGNED_IN != 0) && bus.dado[WIDTH-1];
        if (in_neg_s) begin
            in_mag_s = ~bus.dado + WIDTH'(1);
        end else begin
            in_mag_s = bus.dado;
        end
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    // Blank a digit when it and all digits above it are zero; digit 0 always shows.
    always_comb begin
        logic upper_zero;
        blank_s    = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (work_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == BCD_DIGIT_W'(0));
            blank_s[i] = upper_zero;
        end
    end
`else
    // Blanking disabled: mask is constant zero.
    always_comb begin
        blank_s = '0;
    end
`endif

    // Next-state, datapath and result-register logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mag_d      = mag_q;
        work_d     = work_q;
        ovf_work_d = ovf_work_q;
        neg_work_d = neg_work_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        overflow_d = overflow_q;
        blank_d    = blank_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = SHIFT;
                    mag_d      = in_mag_s;
                    neg_work_d = in_neg_s;
                    work_d     = '0;
                    ovf_work_d = 1'b0;
                    cnt_d      = CNT_W'(WIDTH);
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // Bit leaving the top digit means the value exceeds DIGITS digits.
                work_d     = {adj_s[BCD_W-2:0], mag_q[WIDTH-1]};
                ovf_work_d = ovf_work_q | adj_s[BCD_W-1];
                mag_d      = {mag_q[WIDTH-2:0], 1'b0};
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d    = IDLE;
                done_d     = 1'b1;
                bcd_d      = work_q;
                neg_d      = neg_work_q;
                overflow_d = ovf_work_q;
                blank_d    = blank_s;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mag_q      <= '0;
            work_q     <= '0;
            ovf_work_q <= 1'b0;
            neg_work_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            overflow_q <= 1'b0;
            blank_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mag_q      <= mag_d;
            work_q     <= work_d;
            ovf_work_q <= ovf_work_d;
            neg_work_q <= neg_work_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
            overflow_q <= overflow_d;
            blank_q    <= blank_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.neg      = neg_q;
    assign bus.overflow = overflow_q;
    assign bus.blank    = blank_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Bench for bcd_converter: three configurations (unsigned 32b/10 digits,
// signed 32b/10 digits, unsigned 12b/3 digits) share clock and reset.
// A decimal-arithmetic model predicts every output each cycle.
module tb_bcd_converter;

    localparam int NDUT = 3;
    localparam int W_A [NDUT] = '{32, 32, 12};
    localparam int D_A [NDUT] = '{10, 10, 3};
    localparam int S_A [NDUT] = '{0, 1, 0};

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    bcd_converter_if #(.WIDTH(32), .DIGITS(10)) if0 ();
    bcd_converter_if #(.WIDTH(32), .DIGITS(10)) if1 ();
    bcd_converter_if #(.WIDTH(12), .DIGITS(3))  if2 ();

    bcd_converter #(.WIDTH(32), .DIGITS(10), .SIGNED_IN(0)) u_u32 (.clock(clock), .reset(reset), .bus(if0));
    bcd_converter #(.WIDTH(32), .DIGITS(10), .SIGNED_IN(1)) u_s32 (.clock(clock), .reset(reset), .bus(if1));
    bcd_converter #(.WIDTH(12), .DIGITS(3),  .SIGNED_IN(0)) u_u12 (.clock(clock), .reset(reset), .bus(if2));

    logic        st  [NDUT];
    logic [63:0] din [NDUT];

    assign if0.start = st[0];
    assign if0.dado  = din[0][31:0];
    assign if1.start = st[1];
    assign if1.dado  = din[1][31:0];
    assign if2.start = st[2];
    assign if2.dado  = din[2][11:0];

    logic [NDUT-1:0] obusy, odone, oneg, oovf;
    logic [79:0]     obcd [NDUT];
    logic [19:0]     obl  [NDUT];

    assign obusy = {if2.busy, if1.busy, if0.busy};
    assign odone = {if2.done, if1.done, if0.done};
    assign oneg  = {if2.neg, if1.neg, if0.neg};
    assign oovf  = {if2.overflow, if1.overflow, if0.overflow};
    assign obcd[0] = {40'd0, if0.bcd};
    assign obcd[1] = {40'd0, if1.bcd};
    assign obcd[2] = {68'd0, if2.bcd};
    assign obl[0]  = {10'd0, if0.blank};
    assign obl[1]  = {10'd0, if1.blank};
    assign obl[2]  = {17'd0, if2.blank};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state
    bit          pend   [NDUT];
    int          acc_at [NDUT];
    logic [79:0] p_bcd  [NDUT];
    bit          p_neg  [NDUT];
    bit          p_ovf  [NDUT];
    logic [19:0] p_bl   [NDUT];
    logic [79:0] e_bcd  [NDUT];
    bit          e_neg  [NDUT];
    bit          e_ovf  [NDUT];
    logic [19:0] e_bl   [NDUT];
    bit          e_done [NDUT];

    task automatic chk(input string nm, input int k, input logic [79:0] got, input logic [79:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, k, cyc, got, want);
        end
    endtask

    // Decimal conversion from the rules: magnitude, then repeated /10.
    task automatic model_conv(input int k, input logic [63:0] v,
                              output logic [79:0] b, output bit n, output bit o, output logic [19:0] bl);
        logic [63:0]     mask;
        longint unsigned mag;
        bit              allz;
        mask = (64'd1 << W_A[k]) - 64'd1;
        v    = v & mask;
        n    = 1'b0;
        mag  = v;
        if (S_A[k] != 0 && v[W_A[k]-1]) begin
            mag = ((~v) + 64'd1) & mask;
            n   = 1'b1;
        end
        b = '0;
        for (int i = 0; i < D_A[k]; i++) begin
            b[4*i +: 4] = 4'(mag % 64'd10);
            mag = mag / 64'd10;
        end
        o    = (mag != 0);
        bl   = '0;
        allz = 1'b1;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        for (int i = D_A[k] - 1; i >= 1; i--) begin
            allz  = allz && (b[4*i +: 4] == 4'd0);
            bl[i] = allz;
        end
`endif
    endtask

    // Model: acceptance, done timing and held results per DUT.
    initial begin
        for (int k = 0; k < NDUT; k++) begin
            pend[k] = 1'b0; acc_at[k] = 0; e_bcd[k] = '0; e_neg[k] = 1'b0;
            e_ovf[k] = 1'b0; e_bl[k] = '0; e_done[k] = 1'b0;
        end
        forever begin
            @(posedge clock);
            cyc++;
            for (int k = 0; k < NDUT; k++) begin
                bit was_busy;
                if (reset) begin
                    pend[k] = 1'b0; e_bcd[k] = '0; e_neg[k] = 1'b0;
                    e_ovf[k] = 1'b0; e_bl[k] = '0; e_done[k] = 1'b0;
                end else begin
                    was_busy  = pend[k] && ((cyc - 1) <= acc_at[k] + W_A[k]);
                    e_done[k] = 1'b0;
                    if (pend[k] && cyc == acc_at[k] + W_A[k] + 1) begin
                        e_bcd[k] = p_bcd[k]; e_neg[k] = p_neg[k];
                        e_ovf[k] = p_ovf[k]; e_bl[k] = p_bl[k];
                        e_done[k] = 1'b1; pend[k] = 1'b0;
                    end
                    if (st[k] && !was_busy) begin
                        pend[k]   = 1'b1;
                        acc_at[k] = cyc;
                        model_conv(k, din[k], p_bcd[k], p_neg[k], p_ovf[k], p_bl[k]);
                    end
                end
            end
        end
    end

    // Compare every DUT output against the model each cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (cyc >= 1) begin
                for (int k = 0; k < NDUT; k++) begin
                    chk("busy",  k, 80'(obusy[k]), 80'(pend[k] && (cyc <= acc_at[k] + W_A[k])));
                    chk("done",  k, 80'(odone[k]), 80'(e_done[k]));
                    chk("bcd",   k, obcd[k], e_bcd[k]);
                    chk("neg",   k, 80'(oneg[k]), 80'(e_neg[k]));
                    chk("ovf",   k, 80'(oovf[k]), 80'(e_ovf[k]));
                    chk("blank", k, 80'(obl[k]), 80'(e_bl[k]));
                end
            end
        end
    end

    // Start a conversion and wait (bounded) for done; returns latency in cycles.
    task automatic run(input int k, input logic [63:0] v, output int lat);
        @(negedge clock);
        st[k]  = 1'b1;
        din[k] = v;
        @(negedge clock);
        st[k] = 1'b0;
        lat   = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clock);
            if (odone[k]) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL timeout dut%0d got=no_done want=done", k);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=hang want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          ndone;
        logic [79:0] mb;
        bit          mn, mo;
        logic [19:0] mbl;
        logic [19:0] bl42, bl0, bl7;

`ifdef BCD_LEADING_ZERO_BLANK_EN
        bl42 = 20'b1111111100;
        bl0  = 20'b1111111110;
        bl7  = 20'b110;
`else
        bl42 = 20'd0;
        bl0  = 20'd0;
        bl7  = 20'd0;
`endif

        reset = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            st[k]  = 1'b0;
            din[k] = 64'd0;
        end
        repeat (3) @(negedge clock);
        chk("rst_busy", 0, 80'(obusy[0]), 80'd0);
        chk("rst_done", 1, 80'(odone[1]), 80'd0);
        chk("rst_bcd",  2, obcd[2], 80'd0);
        reset = 1'b0;

        // pin the model with hand-computed values
        model_conv(0, 64'hFFFFFFFF, mb, mn, mo, mbl);
        chk("model_umax", 0, mb, 80'h4294967295);
        model_conv(1, 64'h80000000, mb, mn, mo, mbl);
        chk("model_mneg", 1, {mb[78:0], mn}, {80'h2147483648, 1'b1} >> 1 << 1 | 80'(1'b1));
        model_conv(2, 64'd1000, mb, mn, mo, mbl);
        chk("model_ovf", 2, {mb[78:0], mo}, 80'h0001);

        // unsigned maximum
        run(0, 64'hFFFFFFFF, lat);
        chk("s1_lat", 0, 80'(lat), 80'd33);
        chk("s1_bcd", 0, obcd[0], 80'h4294967295);
        chk("s1_neg", 0, 80'(oneg[0]), 80'd0);
        chk("s1_ovf", 0, 80'(oovf[0]), 80'd0);

        // minus one
        run(1, 64'hFFFFFFFF, lat);
        chk("s2_bcd", 1, obcd[1], 80'h0000000001);
        chk("s2_neg", 1, 80'(oneg[1]), 80'd1);

        // most negative
        run(1, 64'h80000000, lat);
        chk("s3_bcd", 1, obcd[1], 80'h2147483648);
        chk("s3_neg", 1, 80'(oneg[1]), 80'd1);
        chk("s3_ovf", 1, 80'(oovf[1]), 80'd0);

        // zero, signed
        run(1, 64'd0, lat);
        chk("zero_bcd", 1, obcd[1], 80'd0);
        chk("zero_neg", 1, 80'(oneg[1]), 80'd0);
        chk("zero_ovf", 1, 80'(oovf[1]), 80'd0);

        // overflow on 3 digits
        run(2, 64'd1000, lat);
        chk("s4_lat", 2, 80'(lat), 80'd13);
        chk("s4_bcd", 2, obcd[2], 80'h000);
        chk("s4_ovf", 2, 80'(oovf[2]), 80'd1);
        run(2, 64'd999, lat);
        chk("s4b_bcd", 2, obcd[2], 80'h999);
        chk("s4b_ovf", 2, 80'(oovf[2]), 80'd0);
        run(2, 64'd4095, lat);
        chk("s4c_bcd", 2, obcd[2], 80'h095);
        chk("s4c_ovf", 2, 80'(oovf[2]), 80'd1);
        run(2, 64'd7, lat);
        chk("blank7", 2, 80'(obl[2]), 80'(bl7));

        // blanking
        run(0, 64'd42, lat);
        chk("s6_bcd",   0, obcd[0], 80'h42);
        chk("s6_blank", 0, 80'(obl[0]), 80'(bl42));
        run(0, 64'd0, lat);
        chk("s6z_blank", 0, 80'(obl[0]), 80'(bl0));

        // start while busy is ignored; exactly one done at cycle 33
        @(negedge clock);
        st[0]  = 1'b1;
        din[0] = 64'd12345;
        @(negedge clock);
        st[0] = 1'b0;
        ndone = 0;
        lat   = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clock);
            if (n == 4) begin
                st[0]  = 1'b1;
                din[0] = 64'd777;
            end else if (n == 5) begin
                st[0] = 1'b0;
            end
            if (odone[0]) begin
                ndone++;
                if (lat < 0) lat = n;
            end
        end
        chk("s5_ndone", 0, 80'(ndone), 80'd1);
        chk("s5_lat",   0, 80'(lat), 80'd33);
        chk("s5_bcd",   0, obcd[0], 80'h12345);

        // reset mid-conversion aborts with no done; start during reset ignored
        @(negedge clock);
        st[0]  = 1'b1;
        din[0] = 64'd999;
        @(negedge clock);
        st[0] = 1'b0;
        repeat (9) @(negedge clock);
        reset  = 1'b1;
        st[0]  = 1'b1;
        din[0] = 64'd55;
        @(negedge clock);
        reset = 1'b0;
        st[0] = 1'b0;
        ndone = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (odone[0]) ndone++;
        end
        chk("s5r_ndone", 0, 80'(ndone), 80'd0);
        chk("s5r_busy",  0, 80'(obusy[0]), 80'd0);
        chk("s5r_bcd",   0, obcd[0], 80'd0);
        chk("s5r_neg",   0, 80'(oneg[0]), 80'd0);
        chk("s5r_ovf",   0, 80'(oovf[0]), 80'd0);
        chk("s5r_blank", 0, 80'(obl[0]), 80'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
